// File: rtl/uart0_rx.sv
// UART0 receiver: 2-flop sync, 8N1 deserialiser, RX FIFO, 4-register CPU window.
// Optional even-parity bit when UART0_RX_PARITY_EN is defined.
module uart0_rx #(
  parameter logic [15:0] DIVISOR_RESET = 16'd104,
  parameter int          FIFO_DEPTH    = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_addr,
  input  logic [7:0] i_data,
  input  logic       i_rw,
  input  logic       i_en,
  output logic [7:0] o_data,
  input  logic       i_rx,
  output logic       o_irq
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t        state;
  logic          rx_m, rx_s;
  logic [15:0]   cnt, div_l, divisor, eff_div;
  logic [2:0]    bitn;
  logic [7:0]    shreg;
  logic          armed, par_bad;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          ovr, frm, par_flag;
  logic          rd, wr, empty, full, pop;
  logic          push_req, push_ok, ovr_set, frm_set;
  logic [7:0]    clr, status;

  assign eff_div = (divisor < 16'd2) ? 16'd2 : divisor;

  assign rd    = i_en & i_rw;
  assign wr    = i_en & ~i_rw;
  assign empty = (count == '0);
  assign full  = (count == CW'(FIFO_DEPTH));
  assign pop   = rd && (i_addr == 2'd0) && !empty;
  assign clr   = (wr && i_addr == 2'd1) ? i_data : 8'h00;

  // stop-bit sample point: push a good byte, flag a bad stop
  assign push_req = (state == S_STOP) && (cnt == '0)
                  && rx_s && !par_bad;
  assign frm_set  = (state == S_STOP) && (cnt == '0) && !rx_s;
  // a pop in the same cycle frees the slot the push needs
  assign push_ok  = push_req && (!full || pop);
  assign ovr_set  = push_req && full && !pop;

  assign status = {3'b000, par_flag, frm, ovr, full, !empty};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      div_l   <= DIVISOR_RESET;
      bitn    <= '0;
      shreg   <= '0;
      armed   <= 1'b0;
      par_bad <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state <= S_START;
            div_l <= eff_div;
            cnt   <= eff_div >> 1;
          end
        end
        S_START: begin
          if (cnt == 16'd1) begin
            if (rx_s) begin
              state <= S_IDLE;
            end else begin
              state   <= S_DATA;
              cnt     <= div_l - 16'd1;
              bitn    <= '0;
              par_bad <= 1'b0;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (cnt == '0) begin
            shreg <= {rx_s, shreg[7:1]};
            cnt   <= div_l - 16'd1;
            bitn  <= bitn + 3'd1;
            if (bitn == 3'd7) begin
`ifdef UART0_RX_PARITY_EN
              state <= S_PAR;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_PAR: begin
          if (cnt == '0) begin
            par_bad <= rx_s ^ (^shreg);
            cnt     <= div_l - 16'd1;
            state   <= S_STOP;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (cnt == '0) begin
            state <= S_IDLE;
            // disarm until the line returns high: one error per break
            if (!rx_s) armed <= 1'b0;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wptr] <= shreg;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ovr <= 1'b0;
      frm <= 1'b0;
    end else begin
      ovr <= ovr_set | (ovr & ~clr[2]);
      frm <= frm_set | (frm & ~clr[3]);
    end
  end

`ifdef UART0_RX_PARITY_EN
  logic par_set;
  assign par_set = (state == S_PAR) && (cnt == '0)
                 && (rx_s != ^shreg);

  always_ff @(posedge i_clk) begin
    if (i_reset) par_flag <= 1'b0;
    else         par_flag <= par_set | (par_flag & ~clr[4]);
  end
`else
  assign par_flag = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      divisor <= DIVISOR_RESET;
    end else if (wr) begin
      if (i_addr == 2'd2) divisor[7:0]  <= i_data;
      if (i_addr == 2'd3) divisor[15:8] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_data <= '0;
    end else if (rd) begin
      unique case (i_addr)
        2'd0:    o_data <= empty ? 8'h00 : mem[rptr];
        2'd1:    o_data <= status;
        2'd2:    o_data <= divisor[7:0];
        default: o_data <= divisor[15:8];
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) o_irq <= 1'b0;
    else         o_irq <= !empty | ovr | frm | par_flag;
  end

endmodule

// File: tb/tb_uart0_rx.sv
// Bench for uart0_rx: directed + random frames against a queue-based model.
module tb_uart0_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       rw = 1'b1;
  logic       en = 1'b0;
  logic [7:0] rdata;
  logic       rx = 1'b1;
  logic       irq;

  uart0_rx dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_addr  (addr),
    .i_data  (wdata),
    .i_rw    (rw),
    .i_en    (en),
    .o_data  (rdata),
    .i_rx    (rx),
    .o_irq   (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails = 0;
  int div = 104;
  int t_start, t_irq;
  logic [7:0] q[$];
  logic m_ovr = 0, m_frm = 0, m_par = 0;
  logic [7:0] r;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_stat();
    return {3'b000, m_par, m_frm, m_ovr, q.size() == 4, q.size() != 0};
  endfunction

  function automatic logic [7:0] m_pop();
    if (q.size() == 0) return 8'h00;
    return q.pop_front();
  endfunction

  // model of one received frame
  function automatic void m_frame(input logic [7:0] b, input logic stop,
                                  input logic pbad);
    if (pbad) m_par = 1;
    if (!stop) m_frm = 1;
    else if (!pbad) begin
      if (q.size() < 4) q.push_back(b);
      else m_ovr = 1;
    end
  endfunction

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    addr = a; rw = 1; en = 1;
    @(negedge clk);
    en = 0;
    d = rdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    addr = a; wdata = d; rw = 0; en = 1;
    @(negedge clk);
    en = 0; rw = 1;
  endtask

  task automatic set_div(input int d);
    wr(2, d[7:0]);
    wr(3, d[15:8]);
    div = d;
  endtask

  task automatic bitq(input logic v);
    rx = v;
    repeat (div) begin
      @(negedge clk);
      if (irq && t_irq < 0) t_irq = cyc;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop,
                      input logic pflip);
    // index of the first edge that captures the start bit
    t_start = cyc + 1;
    t_irq = -1;
    bitq(1'b0);
    for (int i = 0; i < 8; i++) bitq(b[i]);
`ifdef UART0_RX_PARITY_EN
    bitq((^b) ^ pflip);
`endif
    bitq(stop);
    m_frame(b, stop, pflip);
  endtask

  task automatic chk_stat(input string tag);
    rd(1, r);
    chk(tag, r, m_stat());
  endtask

  task automatic chk_data(input string tag);
    logic [7:0] e;
    e = m_pop();
    rd(0, r);
    chk(tag, r, e);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_odata", rdata, 8'h00);
    chk("rst_irq", irq, 1'b0);
    rd(1, r); chk("rst_status", r, 8'h00);
    rd(2, r); chk("rst_divlo", r, 8'h68);
    rd(3, r); chk("rst_divhi", r, 8'h00);

    set_div(16);
    rd(2, r); chk("div_lo_wr", r, 8'h10);
    send(8'h5A, 1, 0);
    chk("5a_irq_latency",
        (t_irq >= 0) && (t_irq - t_start <= div / 2 + 9 * div + 3), 1'b1);
    chk_stat("5a_status");
    chk_data("5a_data");
    chk_stat("5a_status_after");
    @(negedge clk);
    chk("5a_irq_drop", irq, 1'b0);

    for (int i = 1; i <= 5; i++) send(8'(i), 1, 0);
    chk_stat("ovr_status");
    chk("ovr_irq", irq, 1'b1);
    for (int i = 0; i < 4; i++) chk_data("ovr_data");
    chk_stat("ovr_only");
    wr(1, 8'h04); m_ovr = 0;
    chk_stat("ovr_cleared");
    chk_data("empty_read");
    @(negedge clk);
    chk("ovr_irq_drop", irq, 1'b0);

    send(8'h77, 0, 0);
    rx = 0;
    repeat (20 * div) @(negedge clk);
    chk_stat("break_frm");
    wr(1, 8'h08); m_frm = 0;
    repeat (20 * div) @(negedge clk);
    chk_stat("break_once");
    chk("break_irq", irq, 1'b0);
    rx = 1;
    repeat (2 * div) @(negedge clk);
    send(8'hA5, 1, 0);
    chk_data("after_break");

    rx = 0;
    repeat (4) @(negedge clk);
    rx = 1;
    repeat (3 * div) @(negedge clk);
    chk_stat("glitch_status");
    chk("glitch_irq", irq, 1'b0);

    bitq(1'b0);
    bitq(1'b1); bitq(1'b1);
    rx = 1;
    repeat (div / 2) @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    q.delete(); m_ovr = 0; m_frm = 0; m_par = 0;
    @(negedge clk);
    rd(2, r); chk("rst2_divlo", r, 8'h68);
    set_div(16);
    repeat (2 * div) @(negedge clk);
    send(8'h3C, 1, 0);
    chk_stat("rst2_status");
    chk_data("rst2_data");
    chk_stat("rst2_empty");

`ifdef UART0_RX_PARITY_EN
    send(8'h03, 1, 1);
    chk_stat("par_bad");
    wr(1, 8'h10); m_par = 0;
    send(8'h03, 1, 0);
    chk_stat("par_good_status");
    chk_data("par_good_data");
`endif

    for (int g = 0; g < 4; g++) begin
      int n;
      set_div($urandom_range(6, 24));
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) send(8'($urandom), 1, 0);
      chk_stat("rnd_status");
      for (int k = 0; k <= n && k <= 4; k++) chk_data("rnd_data");
      if (m_ovr) begin
        wr(1, 8'h04); m_ovr = 0;
      end
      chk_stat("rnd_final");
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/uart0_rx.md
Name: uart0_rx

Overview:
- Serial receiver for UART0. Consumes the GPIO pin-mux output o_uart0_rx, which is the line from the lowest-numbered pin in UART0_RX mode, or 0 when no pin is in that mode.
- Deserialises 8N1 frames and buffers the bytes in a small FIFO.
- Exposes data, status and baud divisor to the 6502 through a 4-register memory-mapped window.

Parameters:
- DIVISOR_RESET, 16'd104, clocks per bit after reset (12 MHz / 115200).
- FIFO_DEPTH, 4, receive FIFO entries; must be a power of two, at least 2.

Ports:
- i_clk  in  1  system clock; all logic on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_addr  in  2  register select.
- i_data  in  8  CPU write data.
- i_rw  in  1  1 = read, 0 = write.
- i_en  in  1  one-cycle access strobe; an access happens only in a cycle with i_en=1.
- o_data  out  8  registered read data.
- i_rx  in  1  serial line from gpio o_uart0_rx; asynchronous to i_clk.
- o_irq  out  1  level interrupt request.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset clears:
  - FIFO empty; all status flags 0.
  - divisor = DIVISOR_RESET.
  - FSM = IDLE.
  - o_data = 0, o_irq = 0.
  - Synchronizer flops set to 1.
- Reset mid-frame discards the partial byte. No push occurs.
- Register map:
  - 0 DATA (R): pops the FIFO head. If the FIFO is empty, returns 0 and does not pop. Writes are ignored.
  - 1 STATUS (R): bit0 avail, bit1 full, bit2 overrun, bit3 framing, bit4 parity (optional feature), bits 7:5 = 0.
  - 1 STATUS (W): write-1-to-clear bits 2..4.
  - 2 DIV_LO (R/W): divisor bits 7:0.
  - 3 DIV_HI (R/W): divisor bits 15:8.
- Read latency: o_data is updated on the clock edge where i_en && i_rw. It holds that value until the next read. Writes do not change o_data.
- Effective divisor = max(divisor, 2). It is latched at start-bit detection; a divisor write mid-frame takes effect on the next frame.
- i_rx passes through a 2-flop synchronizer, giving rx_s.
- FSM:
  - IDLE: if rx_s=0 and armed=1 → START, cnt = div>>1.
  - START: cnt decrements to 0. Then:
    - rx_s=1 → IDLE (glitch rejected).
    - rx_s=0 → DATA, cnt = div-1, bit = 0.
  - DATA: at cnt=0, sample rx_s into the shift register LSB-first and reload cnt. After bit 7 → STOP (PARITY if the optional feature is built).
  - STOP: at cnt=0, sample:
    - 1 → push the byte → IDLE.
    - 0 → set framing, discard the byte, armed = 0 → IDLE.
  - armed is set whenever rx_s=1 in IDLE. A held-low line (break or unconnected pin) therefore produces exactly one framing error, not a stream of frames.
- Push when the FIFO is full: byte dropped, overrun set. The FIFO contents are unchanged.
- Push and pop in the same cycle: both occur. Count unchanged; o_data gets the old head.
- Pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.
- The sticky flags (overrun, framing, parity) hold until cleared by write-1-to-clear or reset.
- If a set event and a clear happen in the same cycle, set wins.
- o_irq is registered: avail | overrun | framing | parity. It goes high one cycle after the triggering state change.

Optional Feature:
- UART0_RX_PARITY_EN
- Defined:
  - A PARITY state sits between DATA and STOP and samples one even-parity bit.
  - A mismatch sets STATUS bit4 and marks the byte for discard at STOP. The FSM still checks the stop bit.
- Undefined:
  - No PARITY state; frame is 8N1.
  - bit4 reads 0 and writes to it are ignored.

Test Plan:
- Reset, then read regs 1/2/3 → 0x00, 0x68, 0x00; o_irq = 0.
- DIV=16; drive frame 0x5A (start 0, LSB-first, stop 1) → avail=1 and o_irq=1 within div/2+9*div+3 clocks; DATA read → 0x5A; STATUS → 0x00; o_irq drops.
- Send 5 frames 0x01..0x05 with FIFO_DEPTH=4 and no reads → STATUS = 0x07 (avail, full, overrun); four reads → 0x01..0x04; write 0x04 to STATUS → overrun cleared.
- Frame with stop bit 0, then hold i_rx low for 40 bit-times → exactly one framing error, FIFO empty; release high, send 0xA5 → received correctly.
- 4-clock low pulse with DIV=16 → glitch rejected, no push, no flags set.
- Assert i_reset mid-DATA of frame 0xFF, release, send 0x3C → only 0x3C in FIFO.
- UART0_RX_PARITY_EN defined: frame 0x03 with parity bit 1 → bit4 set, no push. Frame 0x03 with parity bit 0 → byte 0x03 received.
